// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ receiver: measures high-pulse widths, rebuilds 24-bit
// pixel words MSB first, numbers them within the frame and flags protocol errors.
module ws2812_rx #(
  parameter int BIT_THRESH = 30,
  parameter int MIN_HIGH   = 5,
  parameter int HIGH_MAX   = 60,
  parameter int RST_CYCLES = 2500
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        led_data_in,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [5:0]  pix_num,
  output logic        frame_done,
  output logic [6:0]  frame_len,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam logic [15:0] LP_THR  = 16'(BIT_THRESH);
  localparam logic [15:0] LP_MIN  = 16'(MIN_HIGH);
  localparam logic [15:0] LP_HMAX = 16'(HIGH_MAX);
  localparam logic [15:0] LP_RST  = 16'(RST_CYCLES);

  typedef enum logic [1:0] {
    S_WAIT_RST = 2'd0,
    S_IDLE     = 2'd1,
    S_HIGH     = 2'd2,
    S_LOW      = 2'd3
  } state_t;

  function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [6:0] f_sat_inc7(input logic [6:0] v);
    return (v == 7'd127) ? v : v + 7'd1;
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_sync1, r_sync2, r_dly;
  logic [15:0] r_hi_cnt, r_lo_cnt, w_hi_nxt, w_lo_nxt, w_hi_inc, w_lo_inc;
  logic [4:0]  r_bit_cnt, w_bit_nxt;
  logic [23:0] r_shift, w_shift_nxt;
  logic [5:0]  r_idx, w_idx_nxt;
  logic [6:0]  r_fcnt, w_fcnt_nxt;
  logic        w_rise, w_fall, w_bit;
  logic        w_pv, w_fd, w_fe;
  logic [23:0] w_pdata;
  logic [5:0]  w_pnum;
  logic [6:0]  w_flen;

  assign w_rise   = r_sync2 & ~r_dly;
  assign w_fall   = ~r_sync2 & r_dly;
  assign w_hi_inc = f_sat_inc16(r_hi_cnt);
  assign w_lo_inc = f_sat_inc16(r_lo_cnt);
  assign w_bit    = (r_hi_cnt >= LP_THR);
  assign rx_busy  = (r_state == S_HIGH) || (r_state == S_LOW);

  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi_cnt;
    w_lo_nxt    = r_lo_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_fcnt_nxt  = r_fcnt;
    w_pv        = 1'b0;
    w_pdata     = pix_data;
    w_pnum      = pix_num;
    w_fd        = 1'b0;
    w_flen      = frame_len;
    w_fe        = 1'b0;
    case (r_state)
      S_WAIT_RST: begin
        if (r_sync2) begin
          w_lo_nxt = 16'd0;
        end else if (w_lo_inc >= LP_RST) begin
          w_lo_nxt    = 16'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_lo_nxt = w_lo_inc;
        end
      end
      S_IDLE: begin
        if (w_rise) begin
          w_hi_nxt    = 16'd1;
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_fall) begin
          if (r_hi_cnt < LP_MIN) begin
            w_fe        = 1'b1;
            w_state_nxt = S_WAIT_RST;
          end else begin
            w_shift_nxt = {r_shift[22:0], w_bit};
            if (r_bit_cnt == 5'd23) begin
              w_pv       = 1'b1;
              w_pdata    = w_shift_nxt;
              w_pnum     = r_idx;
              w_idx_nxt  = r_idx + 6'd1;
              w_fcnt_nxt = f_sat_inc7(r_fcnt);
              w_bit_nxt  = 5'd0;
            end else begin
              w_bit_nxt = r_bit_cnt + 5'd1;
            end
            w_lo_nxt    = 16'd1;
            w_state_nxt = S_LOW;
          end
        end else if (w_hi_inc >= LP_HMAX) begin
          w_fe        = 1'b1;
          w_state_nxt = S_WAIT_RST;
        end else begin
          w_hi_nxt = w_hi_inc;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_hi_nxt    = 16'd1;
          w_state_nxt = S_HIGH;
        end else if (w_lo_inc >= LP_RST) begin
          // A gap with a partial pixel pending is an error, not a frame end.
          if (r_bit_cnt == 5'd0) begin
            w_fd   = 1'b1;
            w_flen = r_fcnt;
          end else begin
            w_fe = 1'b1;
          end
          w_idx_nxt   = 6'd0;
          w_fcnt_nxt  = 7'd0;
          w_bit_nxt   = 5'd0;
          w_lo_nxt    = 16'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_lo_nxt = w_lo_inc;
        end
      end
      default: w_state_nxt = S_WAIT_RST;
    endcase
    if ((w_state_nxt == S_WAIT_RST) && (r_state != S_WAIT_RST)) begin
      w_bit_nxt   = 5'd0;
      w_idx_nxt   = 6'd0;
      w_fcnt_nxt  = 7'd0;
      w_shift_nxt = 24'd0;
      w_lo_nxt    = 16'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_dly      <= 1'b0;
      r_state    <= S_WAIT_RST;
      r_hi_cnt   <= 16'd0;
      r_lo_cnt   <= 16'd0;
      r_bit_cnt  <= 5'd0;
      r_shift    <= 24'd0;
      r_idx      <= 6'd0;
      r_fcnt     <= 7'd0;
      pix_valid  <= 1'b0;
      pix_data   <= 24'd0;
      pix_num    <= 6'd0;
      frame_done <= 1'b0;
      frame_len  <= 7'd0;
      frame_err  <= 1'b0;
    end else begin
      r_sync1    <= led_data_in;
      r_sync2    <= r_sync1;
      r_dly      <= r_sync2;
      r_state    <= w_state_nxt;
      r_hi_cnt   <= w_hi_nxt;
      r_lo_cnt   <= w_lo_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_idx      <= w_idx_nxt;
      r_fcnt     <= w_fcnt_nxt;
      pix_valid  <= w_pv;
      pix_data   <= w_pdata;
      pix_num    <= w_pnum;
      frame_done <= w_fd;
      frame_len  <= w_flen;
      frame_err  <= w_fe;
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives NRZ pixels/gaps/faults on the line and
// checks decoded words, indices, frame pulses and latency against hand values.
module tb_ws2812_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        led_data_in;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [5:0]  pix_num;
  logic        frame_done;
  logic [6:0]  frame_len;
  logic        frame_err;
  logic        rx_busy;

  ws2812_rx dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .led_data_in(led_data_in),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_num    (pix_num),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #10 sys_clk = ~sys_clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_fd = 0;
  int          n_fe = 0;
  int          pv_cyc = 0;
  int          fe_cyc = 0;
  int          fall_cyc = 0;
  int          rise_cyc = 0;
  logic [6:0]  last_flen = 7'd0;
  logic [23:0] q_data[$];
  logic [5:0]  q_num[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (pix_valid) begin
        q_data.push_back(pix_data);
        q_num.push_back(pix_num);
        pv_cyc <= cyc;
      end
      if (frame_done) begin
        n_fd      <= n_fd + 1;
        last_flen <= frame_len;
      end
      if (frame_err) begin
        n_fe   <= n_fe + 1;
        fe_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gap(input int n);
    led_data_in = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b, input int th, input int tl);
    led_data_in = 1'b1;
    repeat (th) @(negedge sys_clk);
    led_data_in = 1'b0;
    fall_cyc = cyc;
    repeat (tl) @(negedge sys_clk);
  endtask

  // slow = datasheet-like timing; otherwise a compressed timing that
  // still sits on the correct side of both thresholds.
  task automatic send_pix(input logic [23:0] d, input logic slow);
    for (int i = 23; i >= 0; i--) begin
      if (slow) send_bit(d[i], d[i] ? 40 : 20, d[i] ? 22 : 42);
      else      send_bit(d[i], d[i] ? 31 : 8, 6);
    end
  endtask

  initial begin
    int b, fd0, fe0;
    logic [23:0] px3 [3];
    px3[0] = 24'hFFFFFF;
    px3[1] = 24'h000000;
    px3[2] = 24'hA5A5A5;

    sys_rst_n   = 1'b0;
    led_data_in = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("rst_pv",   pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_num",  pix_num, 0);
    chk("rst_flags", {frame_done, frame_err, rx_busy}, 0);
    chk("rst_flen", frame_len, 0);
    sys_rst_n = 1'b1;
    gap(2600);

    // Single pixel, datasheet timing.
    b = q_data.size(); fd0 = n_fd; fe0 = n_fe;
    send_pix(24'h00FF00, 1'b1);
    gap(3000);
    chk("t1_npix", q_data.size() - b, 1);
    chk("t1_data", q_data[b], 24'h00FF00);
    chk("t1_num",  q_num[b], 0);
    chk("t1_lat",  pv_cyc - fall_cyc, 3);
    chk("t1_nfd",  n_fd - fd0, 1);
    chk("t1_flen", last_flen, 1);
    chk("t1_nfe",  n_fe - fe0, 0);

    // Two identical 3-pixel frames; indices restart each frame.
    for (int f = 0; f < 2; f++) begin
      b = q_data.size(); fd0 = n_fd;
      for (int p = 0; p < 3; p++) send_pix(px3[p], 1'b0);
      gap(2600);
      chk("t2_npix", q_data.size() - b, 3);
      for (int p = 0; p < 3; p++) begin
        chk("t2_data", q_data[b+p], px3[p]);
        chk("t2_num",  q_num[b+p], p);
      end
      chk("t2_nfd",  n_fd - fd0, 1);
      chk("t2_flen", last_flen, 3);
    end

    // 65 pixels: index wraps 63 -> 0, length counts past 63.
    b = q_data.size(); fd0 = n_fd;
    for (int p = 0; p < 65; p++) send_pix({16'h0, 8'(p)}, 1'b0);
    gap(2600);
    chk("t3_npix",  q_data.size() - b, 65);
    chk("t3_num63", q_num[b+63], 63);
    chk("t3_num64", q_num[b+64], 0);
    chk("t3_data64", q_data[b+64], 24'h000040);
    chk("t3_nfd",   n_fd - fd0, 1);
    chk("t3_flen",  last_flen, 65);

    // Glitch after 10 bits, a pixel that must be ignored, then a good frame.
    b = q_data.size(); fd0 = n_fd; fe0 = n_fe;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 31, 6);
    led_data_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    gap(20);
    chk("t4_nfe", n_fe - fe0, 1);
    send_pix(24'h123456, 1'b0);
    gap(2600);
    chk("t4_ignored", q_data.size() - b, 0);
    send_pix(24'hC3C3C3, 1'b0);
    gap(2600);
    chk("t4_npix", q_data.size() - b, 1);
    chk("t4_data", q_data[b], 24'hC3C3C3);
    chk("t4_num",  q_num[b], 0);
    chk("t4_nfd",  n_fd - fd0, 1);
    chk("t4_nfe2", n_fe - fe0, 1);

    // Stuck high: rise seen 2 edges after the pin, hi_cnt would reach 60 on
    // the 60th synchronized high cycle, error registered on that edge.
    b = q_data.size(); fd0 = n_fd; fe0 = n_fe;
    for (int i = 0; i < 3; i++) send_bit(1'b0, 8, 6);
    led_data_in = 1'b1;
    rise_cyc = cyc;
    repeat (100) @(negedge sys_clk);
    gap(2600);
    chk("t5_nfe",   n_fe - fe0, 1);
    chk("t5_errat", fe_cyc - rise_cyc, 62);
    for (int i = 0; i < 12; i++) send_bit(1'b1, 31, 6);
    gap(2600);
    chk("t5_nfe2", n_fe - fe0, 2);
    chk("t5_nfd",  n_fd - fd0, 0);
    chk("t5_npix", q_data.size() - b, 0);

    // Reset mid-pixel at bit 15.
    send_pix(24'h5A5A5A, 1'b0);
    for (int i = 0; i < 15; i++) send_bit(1'b1, 31, 6);
    led_data_in = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("t6_busy",  rx_busy, 1);
    chk("t6_pdata", pix_data, 24'h5A5A5A);
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rdata", pix_data, 0);
    chk("t6_rnum",  pix_num, 0);
    chk("t6_rflen", frame_len, 0);
    chk("t6_rflags", {pix_valid, frame_done, frame_err, rx_busy}, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n   = 1'b1;
    led_data_in = 1'b0;
    repeat (5) @(negedge sys_clk);
    b = q_data.size(); fd0 = n_fd;
    send_pix(24'h3C3C3C, 1'b0);
    gap(100);
    chk("t6_ignored", q_data.size() - b, 0);
    chk("t6_idle",    rx_busy, 0);
    gap(2600);
    send_pix(24'h0F0F0F, 1'b0);
    gap(2600);
    chk("t6_npix", q_data.size() - b, 1);
    chk("t6_data", q_data[b], 24'h0F0F0F);
    chk("t6_num",  q_num[b], 0);
    chk("t6_flen", last_flen, 1);
    chk("t6_nfd",  n_fd - fd0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
Single-wire WS2812 NRZ decoder: the receive end of the LED protocol driven by ws2812_ctrl. It measures high-pulse widths on a serial line, rebuilds 24-bit pixel words (MSB first, wire order G-R-B), and tags each word with its position in the frame. The reset/latch gap delimits frames. Used for loopback checking of the transmit path and for monitoring the output of a daisy-chained strip.

Parameters:
- BIT_THRESH, 30: high width in sys_clk cycles at or above which a bit decodes as 1 (0.6 us at 50 MHz).
- MIN_HIGH, 5: high pulses shorter than this are glitches and raise an error.
- HIGH_MAX, 60: high width at which the bit is aborted as a stuck-high error.
- RST_CYCLES, 2500: continuous low cycles that end a frame (50 us at 50 MHz); maximum 65535.

Ports:
- sys_clk  input  1  system clock (50 MHz nominal).
- sys_rst_n  input  1  asynchronous active-low reset.
- led_data_in  input  1  asynchronous serial line.
- pix_valid  output  1  one-cycle pulse; pix_data and pix_num are valid in that cycle.
- pix_data  output  24  decoded word; first-received bit in [23].
- pix_num  output  6  index of the pixel within the frame (0-based), modulo 64.
- frame_done  output  1  one-cycle pulse at a clean frame end.
- frame_len  output  7  pixels in the completed frame, saturating at 127; updated with frame_done.
- frame_err  output  1  one-cycle pulse on any protocol error.
- rx_busy  output  1  high in states HIGH and LOW.

Behaviour:
- Reset is async and active-low, and it wins at any time, including mid-bit. All outputs go to 0, the counters and shift register clear, and the FSM enters WAIT_RST.
- Input path: 2-FF synchronizer, then a 1-FF delay for edge detection (rise/fall from the synchronized value). Every registered output appears 3 sys_clk cycles after the causing pin edge.
- Width counters are 16 bits and saturate.
- WAIT_RST: counts consecutive low cycles; any high clears the count. When the count reaches RST_CYCLES, go to IDLE. Nothing is decoded here. Entering this state clears bit_cnt, pix index and frame pixel count.
- IDLE: on rise, hi_cnt=1 and go to HIGH.
- HIGH: hi_cnt increments each cycle. On fall:
  - hi_cnt < MIN_HIGH: pulse frame_err, go to WAIT_RST.
  - Otherwise shift in bit = (hi_cnt >= BIT_THRESH) and increment bit_cnt (0..23).
  - If this was bit 24: pix_data is the shift result, pix_num = index, pix_valid pulses, index increments (wraps at 64), frame count increments (saturates at 127), bit_cnt returns to 0.
  - Then lo_cnt=1 and go to LOW.
- HIGH timeout: if hi_cnt reaches HIGH_MAX before a fall, pulse frame_err and go to WAIT_RST.
- LOW: lo_cnt increments each cycle.
  - On rise, hi_cnt=1 and go to HIGH.
  - If lo_cnt reaches RST_CYCLES with bit_cnt==0: pulse frame_done, frame_len = frame count, clear index and frame count, go to IDLE.
  - If lo_cnt reaches RST_CYCLES with bit_cnt!=0 (partial pixel): pulse frame_err, no frame_done, clear the same state, go to IDLE.
- pix_data and pix_num hold their values between pulses. frame_len holds until the next frame_done.
- An errored frame never produces frame_done. Pixels already emitted from that frame remain emitted.
- Low period within a bit is not checked, beyond the RST_CYCLES gap.

Test Plan:
- Idle line low 2500 cycles, then frame 0x00FF00 (T1H 40/T1L 22, T0H 20/T0L 42 cycles), then 3000 low cycles. Required: one pix_valid, pix_data=0x00FF00, pix_num=0, then frame_done with frame_len=1, frame_err never. Measure the 3-cycle latency from the last falling edge to pix_valid.
- After a gap, 3-pixel frame 0xFFFFFF, 0x000000, 0xA5A5A5. Required: three pix_valid with pix_num 0,1,2 and exact data, frame_done with frame_len=3. A second identical frame also restarts at pix_num=0.
- Frame of 65 pixels. Required: pix_num wraps 63→0 and frame_len=65.
- 3-cycle high glitch mid-pixel after 10 bits, then a valid frame. Required: frame_err pulse. Nothing decodes until 2500 low cycles; the following frame decodes correctly from pix_num=0.
- Line held high 100 cycles during a bit. Required: frame_err at hi_cnt=60. Then 12 bits followed by a 2500-cycle gap: frame_err, no frame_done.
- Assert sys_rst_n low mid-pixel (bit 15). Required: all outputs 0 immediately. After release, a pixel sent without a preceding 2500-cycle gap is ignored.
